// File: rtl/bus_capture_fifo_pkg.sv
// Shared definitions for the bus capture block: FSM state encodings and
// pointer sizing helper. Used by bus_capture_fifo and sync_fifo.
package bus_capture_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENABLE  = 2'd1,
    ST_SAMPLE  = 2'd2,
    ST_RELEASE = 2'd3
  } cap_state_e;

  // Settle counter is wide enough for SETTLE-1 with SETTLE up to 7.
  localparam int SETTLE_CNT_W = 3;

  // Bits needed to address DEPTH entries; at least 1 so a 1-bit pointer
  // still exists for tiny FIFOs.
  function automatic int ptr_width(input int depth);
    int w;
    w = 1;
    for (int i = 1; i < 16; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bus_capture_fifo_if.sv
// Handshake/bus bundle between the capture block and its environment.
// The capture block is the bus master: it owns OE_N toward the upstream
// register. With BUS_PARITY_EN defined, YP/PERR are added.
interface bus_capture_fifo_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] Y;
  logic             OE_N;
  logic             REQ;
  logic             BUSY;
  logic [WIDTH-1:0] Q;
  logic             VALID;
  logic             RD;
  logic             FULL;
  logic [CW-1:0]    COUNT;
  logic             OVF;
`ifdef BUS_PARITY_EN
  logic             YP;
  logic             PERR;

  modport master (
    input  Y, YP, REQ, RD,
    output OE_N, BUSY, Q, VALID, FULL, COUNT, OVF, PERR
  );
  modport slave (
    output Y, YP, REQ, RD,
    input  OE_N, BUSY, Q, VALID, FULL, COUNT, OVF, PERR
  );
`else
  modport master (
    input  Y, REQ, RD,
    output OE_N, BUSY, Q, VALID, FULL, COUNT, OVF
  );
  modport slave (
    output Y, REQ, RD,
    input  OE_N, BUSY, Q, VALID, FULL, COUNT, OVF
  );
`endif

endinterface

// File: rtl/bus_capture_fifo_sync_fifo.sv
// Small synchronous FIFO for captured words. A pop on a full FIFO frees a
// slot on the same edge, so a simultaneous push is accepted. Read data is
// combinational from the head and forced to zero while empty.
module sync_fifo
  import bus_capture_fifo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            wdata_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            rdata_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [ptr_width(DEPTH):0]   count_o
);
  localparam int PW = ptr_width(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Next pointer/count; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bus_capture_fifo.sv
// Capture controller for a tri-state register bus: drives OE_N low, waits
// SETTLE cycles, samples Y, releases the bus and pushes the word into a
// FIFO read through VALID/RD. Optional BUS_PARITY_EN adds per-word parity
// error tracking (YP in, PERR out).
//
// state   | meaning
// IDLE    | bus released, waiting for REQ
// ENABLE  | OE_N low, settle counter running down
// SAMPLE  | OE_N low, Y captured and pushed on this edge
// RELEASE | OE_N high again, one turnaround cycle before IDLE
module bus_capture_fifo
  import bus_capture_fifo_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic              CP,
  input  logic              MR_N,
  bus_capture_fifo_if.master bus
);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE - 1);

`ifdef BUS_PARITY_EN
  localparam int FW = WIDTH + 1;
`else
  localparam int FW = WIDTH;
`endif

  cap_state_e              state_q;
  logic [SETTLE_CNT_W-1:0] cnt_q;
  logic                    oe_n_q;
  logic                    busy_q;
  logic                    ovf_q;

  logic          fifo_push;
  logic          fifo_full;
  logic          fifo_empty;
  logic [FW-1:0] fifo_wdata;
  logic [FW-1:0] fifo_rdata;
  logic [PW:0]   fifo_count;

  assign fifo_push = (state_q == ST_SAMPLE);

`ifdef BUS_PARITY_EN
  // Upstream drives odd parity, so a correct word has ^{Y,YP} == 1.
  assign fifo_wdata = {~(^{bus.Y, bus.YP}), bus.Y};
  assign bus.PERR   = fifo_rdata[WIDTH];
`else
  assign fifo_wdata = bus.Y;
`endif

  assign bus.Q     = fifo_rdata[WIDTH-1:0];
  assign bus.VALID = ~fifo_empty;
  assign bus.FULL  = fifo_full;
  assign bus.COUNT = fifo_count;
  assign bus.OVF   = ovf_q;
  assign bus.OE_N  = oe_n_q;
  assign bus.BUSY  = busy_q;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CP),
    .rst_n   (MR_N),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (bus.RD),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Capture sequencer with registered OE_N/BUSY and sticky overflow flag.
  always_ff @(posedge CP) begin
    if (!MR_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      oe_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.REQ) begin
            state_q <= ST_ENABLE;
            cnt_q   <= SETTLE_LOAD;
            oe_n_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_ENABLE: begin
          if (cnt_q == '0) state_q <= ST_SAMPLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        ST_SAMPLE: begin
          state_q <= ST_RELEASE;
          oe_n_q  <= 1'b1;
          // A same-edge read frees a slot, so only an unread full FIFO drops.
          if (fifo_full && !bus.RD) ovf_q <= 1'b1;
        end
        ST_RELEASE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          oe_n_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bus_capture_fifo.md
Name: bus_capture_fifo

Overview:
- Receiving end of a tri-state register output bus (quad D register driving Y under active-low /OE).
- Owns the upstream /OE line:
  - enables the driver;
  - waits a settle time;
  - samples Y on CP rising edge;
  - releases the bus;
  - pushes the word into a small FIFO.
- Downstream logic reads captured words through a valid/read handshake.

Parameters:
- WIDTH, 4, bus word width (Y and Q).
- DEPTH, 4, FIFO entries; power of two, 2..16.
- SETTLE, 1, CP cycles OE_N is held low before sampling; 1..7.

Ports:
- CP  input  1  clock; all state changes on rising edge.
- MR_N  input  1  synchronous active-low master reset; sampled on CP rising edge.
- Y  input  WIDTH  shared bus from the upstream register's tri-state outputs.
- OE_N  output  1  active-low output enable driven to the upstream register.
- REQ  input  1  capture request; sampled only in IDLE.
- BUSY  output  1  high whenever the FSM is not in IDLE.
- Q  output  WIDTH  FIFO head word; all-zero when empty.
- VALID  output  1  FIFO non-empty.
- RD  input  1  pop head on CP edge when VALID is high; ignored when empty.
- FULL  output  1  count equals DEPTH.
- COUNT  output  $clog2(DEPTH)+1  number of stored words.
- OVF  output  1  sticky; a capture was dropped because the FIFO was full.

Behaviour:
- Reset (MR_N low at a CP edge):
  - FSM goes to IDLE; OE_N=1, BUSY=0.
  - FIFO emptied: COUNT=0, VALID=0, FULL=0, Q=0; OVF=0.
  - Reset overrides any capture in flight; the bus is released on that same edge.
- FSM states: IDLE, ENABLE, SAMPLE, RELEASE.
  - IDLE: OE_N=1. If REQ=1, go to ENABLE and load the settle counter with SETTLE-1.
  - ENABLE: OE_N=0. Decrement the counter; at 0, go to SAMPLE.
  - SAMPLE: OE_N=0. Capture Y on this edge and push; go to RELEASE.
  - RELEASE: OE_N=1. Go to IDLE; REQ is not sampled in this state.
- Latency and throughput:
  - With SETTLE=1: REQ at edge n gives OE_N low after n, Y sampled at edge n+2, word visible on Q/VALID after n+2.
  - Minimum spacing between captures is SETTLE+3 cycles.
- Push when full: the word is discarded, OVF set, FIFO contents unchanged.
- Push and pop on the same edge:
  - Both succeed when 0<COUNT<DEPTH; COUNT unchanged.
  - When full at SAMPLE, the pop happens first, so the push succeeds and OVF is not set.
  - When empty, only the push happens.
- Pointers: read/write pointers wrap modulo DEPTH. COUNT is separate, saturating at 0 and DEPTH.
- Q is combinational from the head entry; no read latency. It holds its value while RD=0.
- Y is only meaningful while OE_N=0. The block never samples Y in other states.

Optional Feature:
- Macro: BUS_PARITY_EN.
- With it:
  - Adds input YP (1 bit, odd parity over Y from the upstream) and output PERR (1 bit).
  - Each entry stores a parity-error bit computed at SAMPLE: PERR = ~(^Y ^ YP).
  - The PERR output reflects the head entry; it is 0 when empty or after reset.
- Without it: the ports are absent and no parity storage is built.

Decomposition:
- Shared package/header bus_capture_defs:
  - FSM state encodings (IDLE=2'd0, ENABLE=2'd1, SAMPLE=2'd2, RELEASE=2'd3);
  - a DEPTH-to-pointer-width constant function.
- One natural sub-module: sync_fifo (WIDTH, DEPTH; push, pop, full, empty, count).
- The FSM, settle counter and OVF stay in the top.

Test Plan:
- Reset: MR_N=0 for 2 edges with REQ=1 -> OE_N=1, BUSY=0, COUNT=0, VALID=0, Q=4'b0000, OVF=0.
- Single capture:
  - Stimulus: SETTLE=1, Y=4'b1010, REQ pulsed at edge n.
  - Required: OE_N low during cycles n+1..n+2 only; after edge n+2 Q=4'b1010, VALID=1, COUNT=1; OE_N=1 after n+3.
- Sampling window:
  - Stimulus: Y=4'b0101 while OE_N=1, changed to 4'b1111 while OE_N=0.
  - Required: captured word is 4'b1111.
- Fill and overflow:
  - Stimulus: 5 captures with DEPTH=4 (Y=1,2,3,4,5) and no RD.
  - Required: FULL=1, COUNT=4, OVF=1; reads return 1,2,3,4, then VALID=0.
- Simultaneous push and pop: FIFO full, RD=1 on the SAMPLE edge -> COUNT stays 4, OVF=0, head advances, the new word lands at the tail.
- Reset mid-capture: MR_N low during ENABLE -> OE_N=1 on the next edge, FSM in IDLE, FIFO empty, no word pushed.
